// File: rtl/spi_frame_bridge_if.sv
// spi_frame_bridge_if: host byte-core and FIFO signal bundle.
// master = bridge side, slave = byte core / FIFO side.
// Signals:
//   spi_rx_valid/spi_rx_data   host byte in
//   spi_tx_ready/load/data     host byte out
//   wr_req/ack/data/full       word FIFO write
//   rd_req/ack/data/empty/count word FIFO read
//   cpu_recv_int, err_len, state_dbg
interface spi_frame_bridge_if #(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 11
);
  logic              spi_rx_valid;
  logic [7:0]        spi_rx_data;
  logic              spi_tx_ready;
  logic              spi_tx_load;
  logic [7:0]        spi_tx_data;
  logic              wr_req;
  logic              wr_ack;
  logic [WORD_W-1:0] wr_data;
  logic              wr_full;
  logic              rd_req;
  logic              rd_ack;
  logic [WORD_W-1:0] rd_data;
  logic              rd_empty;
  logic [CNT_W-1:0]  rd_count;
  logic              cpu_recv_int;
  logic              err_len;
  logic [7:0]        state_dbg;

  modport master (
    input  spi_rx_valid, spi_rx_data,
    input  spi_tx_ready,
    output spi_tx_load, spi_tx_data,
    output wr_req, wr_data,
    input  wr_ack, wr_full,
    output rd_req,
    input  rd_ack, rd_data, rd_empty, rd_count,
    output cpu_recv_int, err_len, state_dbg
  );

  modport slave (
    output spi_rx_valid, spi_rx_data,
    output spi_tx_ready,
    input  spi_tx_load, spi_tx_data,
    input  wr_req, wr_data,
    output wr_ack, wr_full,
    input  rd_req,
    output rd_ack, rd_data, rd_empty, rd_count,
    input  cpu_recv_int, err_len, state_dbg
  );
endinterface

// File: rtl/spi_frame_bridge.sv
// spi_frame_bridge: SPI host frames <-> 16-bit word FIFO.
// Host cmds: 0x66 write, 0x77 read, 0x55 status.
// Ports: clk, rst (sync, active high),
//   bus (spi_frame_bridge_if.master): byte core,
//   FIFO write/read handshakes, cpu_recv_int (low =
//   frame ready), err_len pulse, state_dbg.
// Option: SPI_TIMEOUT_EN aborts a stalled write frame.
module spi_frame_bridge #(
  parameter int WORD_W  = 16,
  parameter int LEN_W   = 8,
  parameter int MAX_LEN = 255,
  parameter int CNT_W   = 11,
  parameter int TMO_CYC = 4096
) (
  input logic clk,
  input logic rst,
  spi_frame_bridge_if.master bus
);

  typedef enum logic [4:0] {
    H_IDLE, H_CMD, H_WLEN, H_WHDR,
    H_WB0, H_WB1, H_WPUSH, H_WDONE,
    H_WDROP, H_RLEN, H_RFETCH, H_RHI,
    H_RLO, H_REND, H_SHI, H_SLO
  } hst_t;

  typedef enum logic [2:0] {
    R_IDLE, R_HDR, R_WAIT, R_RDY, R_ACK
  } rds_t;

  localparam int CW =
    (CNT_W + 2 > LEN_W + 1) ? CNT_W + 2 : LEN_W + 1;

  hst_t hs, hs_nx;
  rds_t rs, rs_nx;

  logic [7:0]        byte_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  rem_q;
  logic [LEN_W-1:0]  plen_q;
  logic [15:0]       pack_q;
  logic [15:0]       rword_q;
  logic              wr_pend;

  logic              rx;
  logic              tx_rdy;
  logic              staged;
  logic              rem_last;
  logic              rd_done;
  logic              len_bad;
  logic [LEN_W-1:0]  rx_len;
  logic [CW-1:0]     have;
  logic [CW-1:0]     need;
  logic              tmo_hit;

  logic              tx_go;
  logic [7:0]        tx_byte;
  logic              wr_load;
  logic [WORD_W-1:0] wr_word;
  logic              fetch_req;
  logic              rd_start;
  logic              send_end;
  logic              err_set;
  logic              rd_want;

  assign rx       = bus.spi_rx_valid;
  // load is registered: ignore ready on the load cycle
  assign tx_rdy   = bus.spi_tx_ready & ~bus.spi_tx_load;
  assign staged   = (rs == R_RDY);
  assign rem_last = (rem_q == LEN_W'(1));
  assign rd_done  = bus.rd_req & bus.rd_ack;
  assign rx_len   = LEN_W'(bus.spi_rx_data);
  assign len_bad  =
    {1'b0, rx_len} > (LEN_W + 1)'(MAX_LEN);
  assign have     = CW'({bus.rd_count, 1'b0});
  assign need     = CW'(plen_q) - CW'(1);
  assign bus.state_dbg = {3'b000, hs};

`ifdef SPI_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          in_wr;

  assign in_wr = (hs == H_WLEN) || (hs == H_WB0)
              || (hs == H_WB1) || (hs == H_WDROP);
  assign tmo_hit = in_wr && !rx
                && (tmo_cnt == TW'(TMO_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || !in_wr || rx) tmo_cnt <= '0;
    else                     tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYC;
  assign tmo_hit    = 1'b0;
`endif

  // host FSM: state register
  always_ff @(posedge clk) begin
    if (rst) hs <= H_IDLE;
    else     hs <= hs_nx;
  end

  // host FSM: next state
  always_comb begin
    hs_nx = hs;
    unique case (hs)
      H_IDLE:   if (rx) hs_nx = H_CMD;
      H_CMD: begin
        case (byte_q)
          8'h66:   hs_nx = H_WLEN;
          8'h77:   hs_nx = H_RLEN;
          8'h55:   hs_nx = H_SHI;
          default: hs_nx = H_IDLE;
        endcase
      end
      H_WLEN: begin
        if (tmo_hit)           hs_nx = H_IDLE;
        else if (rx) begin
          if (rx_len == '0)    hs_nx = H_IDLE;
          else if (len_bad)    hs_nx = H_WDROP;
          else                 hs_nx = H_WHDR;
        end
      end
      H_WHDR:   if (!wr_pend) hs_nx = H_WB0;
      H_WB0: begin
        if (tmo_hit)  hs_nx = H_WDONE;
        else if (rx)  hs_nx = rem_last ? H_WPUSH : H_WB1;
      end
      H_WB1:    if (tmo_hit || rx) hs_nx = H_WPUSH;
      H_WPUSH: begin
        if (!wr_pend)
          hs_nx = (rem_q == '0) ? H_WDONE : H_WB0;
      end
      H_WDONE:  if (!wr_pend) hs_nx = H_IDLE;
      H_WDROP: begin
        if (tmo_hit || (rx && rem_last)) hs_nx = H_IDLE;
      end
      H_RLEN: begin
        if (tx_rdy) hs_nx = staged ? H_RFETCH : H_IDLE;
      end
      H_RFETCH: if (rd_done) hs_nx = H_RHI;
      H_RHI: begin
        if (tx_rdy) hs_nx = rem_last ? H_REND : H_RLO;
      end
      H_RLO: begin
        if (tx_rdy) hs_nx = rem_last ? H_REND : H_RFETCH;
      end
      H_REND:   hs_nx = H_IDLE;
      H_SHI:    if (tx_rdy) hs_nx = H_SLO;
      H_SLO:    if (tx_rdy) hs_nx = H_IDLE;
      default:  hs_nx = H_IDLE;
    endcase
  end

  // host FSM: outputs
  always_comb begin
    tx_go     = 1'b0;
    tx_byte   = 8'h00;
    wr_load   = 1'b0;
    wr_word   = '0;
    fetch_req = 1'b0;
    rd_start  = 1'b0;
    send_end  = 1'b0;
    err_set   = tmo_hit
             || (hs == H_WLEN && rx && len_bad);
    unique case (hs)
      H_WHDR: begin
        wr_load = !wr_pend;
        wr_word = WORD_W'({8'h66, 8'(len_q)});
      end
      H_WPUSH: begin
        wr_load = !wr_pend;
        wr_word = WORD_W'(pack_q);
      end
      H_RLEN: begin
        tx_go    = tx_rdy;
        tx_byte  = staged ? 8'(plen_q) : 8'h00;
        rd_start = tx_rdy & staged;
      end
      H_RFETCH: fetch_req = 1'b1;
      H_RHI: begin
        tx_go   = tx_rdy;
        tx_byte = rword_q[15:8];
      end
      H_RLO: begin
        tx_go   = tx_rdy;
        tx_byte = rword_q[7:0];
      end
      H_REND:   send_end = 1'b1;
      H_SHI: begin
        tx_go   = tx_rdy;
        tx_byte = {5'b0, 3'(bus.rd_count >> 8)};
      end
      H_SLO: begin
        tx_go   = tx_rdy;
        tx_byte = 8'(bus.rd_count);
      end
      default: ;
    endcase
  end

  // host datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_q  <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      pack_q  <= '0;
      rword_q <= '0;
    end else begin
      unique case (hs)
        H_IDLE: if (rx) byte_q <= bus.spi_rx_data;
        H_WLEN: if (rx) begin
          len_q <= rx_len;
          rem_q <= rx_len;
        end
        H_WB0: if (rx) begin
          pack_q <= {bus.spi_rx_data, 8'h00};
          rem_q  <= rem_q - 1'b1;
        end
        // timeout flushes the half word as the last one
        H_WB1: begin
          if (tmo_hit) rem_q <= '0;
          else if (rx) begin
            pack_q[7:0] <= bus.spi_rx_data;
            rem_q       <= rem_q - 1'b1;
          end
        end
        H_WDROP: if (rx) rem_q <= rem_q - 1'b1;
        H_RLEN:  if (tx_rdy) rem_q <= plen_q;
        H_RFETCH: if (rd_done) rword_q <= 16'(bus.rd_data);
        H_RHI, H_RLO: if (tx_rdy) rem_q <= rem_q - 1'b1;
        default: ;
      endcase
    end
  end

  // read FSM: state register
  always_ff @(posedge clk) begin
    if (rst) rs <= R_IDLE;
    else     rs <= rs_nx;
  end

  // read FSM: next state
  always_comb begin
    rs_nx = rs;
    unique case (rs)
      R_IDLE: if (!bus.rd_empty) rs_nx = R_HDR;
      R_HDR: begin
        if (rd_done)
          rs_nx = (bus.rd_data[15:8] == 8'h00)
                ? R_IDLE : R_WAIT;
      end
      R_WAIT: if (have >= need) rs_nx = R_RDY;
      R_RDY:  if (rd_start) rs_nx = R_ACK;
      R_ACK:  if (send_end) rs_nx = R_IDLE;
      default: rs_nx = R_IDLE;
    endcase
  end

  // read FSM: outputs
  always_comb begin
    rd_want = (rs == R_HDR)
           || (rs == R_ACK && fetch_req);
  end

  always_ff @(posedge clk) begin
    if (rst) plen_q <= '0;
    else if (rs == R_HDR && rd_done)
      plen_q <= LEN_W'(bus.rd_data[15:8]);
  end

  // handshakes and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.spi_tx_load  <= 1'b0;
      bus.spi_tx_data  <= 8'h00;
      bus.wr_req       <= 1'b0;
      bus.wr_data      <= '0;
      bus.rd_req       <= 1'b0;
      bus.cpu_recv_int <= 1'b1;
      bus.err_len      <= 1'b0;
      wr_pend          <= 1'b0;
    end else begin
      bus.spi_tx_load  <= tx_go;
      if (tx_go) bus.spi_tx_data <= tx_byte;
      bus.err_len      <= err_set;
      bus.cpu_recv_int <= (rs_nx != R_RDY);

      if (wr_load) begin
        bus.wr_data <= wr_word;
        wr_pend     <= 1'b1;
      end
      if (bus.wr_req) begin
        if (bus.wr_ack) begin
          bus.wr_req <= 1'b0;
          wr_pend    <= 1'b0;
        end
      end else if (wr_pend && !bus.wr_full) begin
        bus.wr_req <= 1'b1;
      end

      if (bus.rd_req) begin
        if (bus.rd_ack) bus.rd_req <= 1'b0;
      end else if (rd_want && !bus.rd_empty) begin
        bus.rd_req <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_bridge.sv
// tb_spi_frame_bridge: random host frames vs a
// frame-level model of the bridge.
module tb_spi_frame_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_frame_bridge_if #(.WORD_W(16), .CNT_W(11)) bus ();

  spi_frame_bridge #(
    .WORD_W(16), .LEN_W(8), .MAX_LEN(200),
    .CNT_W(11), .TMO_CYC(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [15:0] rdq[$];
  logic [15:0] wrq[$];
  logic [7:0]  txq[$];
  logic [7:0]  pay[$];
  int          err_cnt = 0;
  int          rdreq_rise = 0;
  int          txviol = 0;
  int          wr_dly = 0;
  int          rd_dly = 0;
  int          tx_busy = 0;
  logic        rd_req_d = 1'b0;
  bit          cnt_ovr = 1'b0;
  logic [10:0] cnt_val = '0;

  // FIFO and byte-core responders
  always @(negedge clk) begin
    if (rst) begin
      bus.wr_ack       = 1'b0;
      bus.rd_ack       = 1'b0;
      bus.spi_tx_ready = 1'b1;
      tx_busy          = 0;
    end else begin
      if (bus.wr_ack) bus.wr_ack = 1'b0;
      else if (bus.wr_req && !bus.wr_full) begin
        if (wr_dly == 0) begin
          bus.wr_ack = 1'b1;
          wrq.push_back(bus.wr_data);
          wr_dly = $urandom_range(0, 3);
        end else wr_dly--;
      end
      if (bus.rd_ack) bus.rd_ack = 1'b0;
      else if (bus.rd_req && rdq.size() > 0) begin
        if (rd_dly == 0) begin
          bus.rd_ack  = 1'b1;
          bus.rd_data = rdq.pop_front();
          rd_dly = $urandom_range(0, 2);
        end else rd_dly--;
      end
      if (bus.spi_tx_load) begin
        if (!bus.spi_tx_ready) txviol++;
        txq.push_back(bus.spi_tx_data);
        bus.spi_tx_ready = 1'b0;
        tx_busy = $urandom_range(2, 6);
      end else if (tx_busy > 0) begin
        tx_busy--;
        if (tx_busy == 0) bus.spi_tx_ready = 1'b1;
      end
      if (bus.err_len) err_cnt++;
      if (bus.rd_req && !rd_req_d) rdreq_rise++;
      rd_req_d = bus.rd_req;
    end
    bus.rd_empty = (rdq.size() == 0);
    bus.rd_count = cnt_ovr ? cnt_val : 11'(rdq.size());
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(logic [7:0] b);
    bus.spi_rx_data  = b;
    bus.spi_rx_valid = 1'b1;
    tick(1);
    bus.spi_rx_valid = 1'b0;
    tick($urandom_range(8, 12));
  endtask

  task automatic wait_tx(int n);
    int k;
    k = 0;
    while (txq.size() < n && k < 3000) begin
      tick(1);
      k++;
    end
  endtask

  task automatic fill_pay(int n);
    pay.delete();
    for (int i = 0; i < n; i++)
      pay.push_back(8'($urandom_range(0, 255)));
  endtask

  // model: header + pairs, odd tail padded; none if
  // len is 0 or too long (too long also flags err_len)
  task automatic do_write(int len);
    logic [15:0] exp[$];
    int e0;
    int xe;
    xe = (len > 200) ? 1 : 0;
    if (len > 0 && len <= 200) begin
      exp.push_back(16'h6600 | 16'(len));
      for (int i = 0; i < len; i += 2)
        exp.push_back({pay[i],
          (i + 1 < len) ? pay[i+1] : 8'h00});
    end
    wrq.delete();
    e0 = err_cnt;
    send_byte(8'h66);
    send_byte(8'(len));
    for (int i = 0; i < len; i++) send_byte(pay[i]);
    tick(30);
    chk("wr_n", wrq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < wrq.size(); i++)
      chk("wr_word", wrq[i], exp[i]);
    chk("wr_err", err_cnt - e0, xe);
    chk("wr_idle", bus.state_dbg, 0);
  endtask

  // model: host sees plen then plen payload bytes
  task automatic do_read(int plen);
    int k;
    rdq.push_back({8'(plen), 8'h00});
    for (int i = 0; i < plen; i += 2)
      rdq.push_back({pay[i], (i + 1 < plen) ? pay[i+1]
                     : 8'($urandom_range(0, 255))});
    k = 0;
    while (bus.cpu_recv_int && k < 200) begin
      tick(1);
      k++;
    end
    chk("int_lo", bus.cpu_recv_int, 0);
    txq.delete();
    send_byte(8'h77);
    wait_tx(plen + 1);
    tick(20);
    chk("rd_n", txq.size(), plen + 1);
    if (txq.size() > 0) chk("rd_len", txq[0], plen);
    for (int i = 0; i < plen && i + 1 < txq.size(); i++)
      chk("rd_byte", txq[i+1], pay[i]);
    chk("int_hi", bus.cpu_recv_int, 1);
    chk("rd_empty", rdq.size(), 0);
  endtask

  task automatic do_status(logic [10:0] v);
    cnt_ovr = 1'b1;
    cnt_val = v;
    txq.delete();
    send_byte(8'h55);
    wait_tx(2);
    tick(10);
    chk("st_n", txq.size(), 2);
    if (txq.size() == 2) begin
      chk("st_hi", txq[0], {5'b0, v[10:8]});
      chk("st_lo", txq[1], v[7:0]);
    end
    cnt_ovr = 1'b0;
  endtask

  initial begin
    int hi;
    int e0;
    int r0;
    rst              = 1'b1;
    bus.spi_rx_valid = 1'b0;
    bus.spi_rx_data  = 8'h00;
    bus.spi_tx_ready = 1'b1;
    bus.wr_ack       = 1'b0;
    bus.wr_full      = 1'b0;
    bus.rd_ack       = 1'b0;
    bus.rd_data      = 16'h0000;
    bus.rd_empty     = 1'b1;
    bus.rd_count     = '0;
    tick(3);
    chk("rst_load", bus.spi_tx_load, 0);
    chk("rst_txd", bus.spi_tx_data, 0);
    chk("rst_wreq", bus.wr_req, 0);
    chk("rst_wdat", bus.wr_data, 0);
    chk("rst_rreq", bus.rd_req, 0);
    chk("rst_int", bus.cpu_recv_int, 1);
    chk("rst_err", bus.err_len, 0);
    chk("rst_state", bus.state_dbg, 0);
    rst = 1'b0;
    tick(3);

    pay = '{8'hA1, 8'hB2, 8'hC3};
    do_write(3);

    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_read(4);

    txq.delete();
    r0 = rdreq_rise;
    send_byte(8'h77);
    wait_tx(1);
    tick(20);
    chk("empty_n", txq.size(), 1);
    if (txq.size() > 0) chk("empty_b", txq[0], 0);
    chk("empty_rreq", rdreq_rise - r0, 0);

    do_status(11'h123);

    fill_pay(0);
    do_write(0);

    send_byte(8'h12);
    tick(3);
    chk("bad_cmd", bus.state_dbg, 0);

    fill_pay(200);
    do_write(200);
    fill_pay(201);
    do_write(201);

    rdq.push_back(16'h0000);
    tick(20);
    chk("zero_hdr", rdq.size(), 0);
    chk("zero_int", bus.cpu_recv_int, 1);

    // stalled FIFO: 2 payload bytes sent while full
    wrq.delete();
    fill_pay(4);
    bus.wr_full = 1'b1;
    send_byte(8'h66);
    send_byte(8'h04);
    send_byte(pay[0]);
    send_byte(pay[1]);
    hi = 0;
    repeat (100) begin
      tick(1);
      if (bus.wr_req) hi++;
    end
    chk("full_req", hi, 0);
    bus.wr_full = 1'b0;
    tick(8);
    send_byte(pay[2]);
    send_byte(pay[3]);
    tick(30);
    chk("full_n", wrq.size(), 3);
    if (wrq.size() == 3) begin
      chk("full_w0", wrq[0], 16'h6604);
      chk("full_w1", wrq[1], {pay[0], pay[1]});
      chk("full_w2", wrq[2], {pay[2], pay[3]});
    end

    wrq.delete();
    e0 = err_cnt;
    send_byte(8'h66);
    send_byte(8'h05);
    send_byte(8'hAA);
`ifdef SPI_TIMEOUT_EN
    tick(30);
    chk("tmo_n", wrq.size(), 2);
    if (wrq.size() == 2) begin
      chk("tmo_w0", wrq[0], 16'h6605);
      chk("tmo_w1", wrq[1], 16'hAA00);
    end
    chk("tmo_err", err_cnt - e0, 1);
    chk("tmo_idle", bus.state_dbg, 0);
`else
    tick(40);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    send_byte(8'hEE);
    tick(30);
    chk("slow_n", wrq.size(), 4);
    if (wrq.size() == 4) begin
      chk("slow_w0", wrq[0], 16'h6605);
      chk("slow_w1", wrq[1], 16'hAABB);
      chk("slow_w2", wrq[2], 16'hCCDD);
      chk("slow_w3", wrq[3], 16'hEE00);
    end
    chk("slow_err", err_cnt - e0, 0);
`endif

    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          fill_pay($urandom_range(1, 12));
          do_write(pay.size());
        end
        1: begin
          fill_pay($urandom_range(1, 10));
          do_read(pay.size());
        end
        default: do_status(11'($urandom_range(0, 2047)));
      endcase
    end

    chk("tx_proto", txviol, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
